// File: rtl/stoch_add_mat_ctrl.sv
// Run controller for a stochastic matrix adder: flushes the datapath, enables it for len cycles
// while counting ones on every Y element, then pulses done with the counts held until next start.
module stoch_add_mat_ctrl #(
  parameter int unsigned NUM_ROWS = 2,
  parameter int unsigned NUM_COLS = 2,
  parameter int unsigned LEN_W    = 8
) (
  input  logic                                          CLK,
  input  logic                                          RST,
  input  logic                                          start,
  input  logic                                          abort,
  input  logic [LEN_W-1:0]                              len,
  input  logic [NUM_ROWS-1:0][NUM_COLS-1:0]             Y,
  output logic                                          dp_en,
  output logic                                          dp_clr,
  output logic                                          busy,
  output logic                                          done,
  output logic [NUM_ROWS-1:0][NUM_COLS-1:0][LEN_W-1:0]  count
);

  typedef enum logic [1:0] {StIdle, StFlush, StRun, StDone} state_e;

  state_e           state_q;
  logic [LEN_W-1:0] rem_q;

  assign dp_en  = (state_q == StRun);
  assign dp_clr = (state_q == StFlush);
  assign busy   = (state_q != StIdle);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
      rem_q   <= '0;
      done    <= 1'b0;
      count   <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            rem_q   <= len;
            count   <= '0;
            state_q <= StFlush;
          end
        end
        StFlush: begin
          if (abort) begin
            state_q <= StIdle;
          end else if (rem_q == '0) begin
            state_q <= StDone;
            done    <= 1'b1;
          end else begin
            state_q <= StRun;
          end
        end
        StRun: begin
          // The aborting cycle still counts: dp_en is high, so its Y is valid.
          for (int unsigned i = 0; i < NUM_ROWS; i++) begin
            for (int unsigned j = 0; j < NUM_COLS; j++) begin
              if (Y[i][j]) count[i][j] <= count[i][j] + LEN_W'(1);
            end
          end
          rem_q <= rem_q - LEN_W'(1);
          if (abort) begin
            state_q <= StIdle;
          end else if (rem_q == LEN_W'(1)) begin
            state_q <= StDone;
            done    <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
